msdf_to_bin_op: RTL and testbench
=================================

MSDF_TO_BIN_OP -- requirements
Module: msdf_to_bin_op

Interface
REQ-001 SHALL have parameter TARGET_PRECISION, default 32'd16, giving the number of MSDF digits per word (P); legal range 2..31.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port dataInArray_0, input, 3 bits: {last, digit[1:0]}; digit value = digit[1] - digit[0], so 10 = +1, 01 = -1, 00 or 11 = 0.
REQ-005 SHALL have port pValidArray_0, input, 1 bit: upstream digit valid.
REQ-006 SHALL have port readyArray_0, output, 1 bit: this block accepts a digit.
REQ-007 SHALL have port dataOutArray_0, output, P+1 bits: two's-complement integer Z, where Z = value * 2^P.
REQ-008 SHALL have port validArray_0, output, 1 bit: the converted word is valid.
REQ-009 SHALL have port nReadyArray_0, input, 1 bit: downstream accepts the word.
REQ-010 SHALL have port frame_err, output, 1 bit: the word was closed at digit P without last; valid only while validArray_0 = 1.

Function
REQ-011 SHALL consume the MSDF digit stream produced by msdf_add_op, most significant digit first (weight 2^-1 first), and produce one parallel word per frame.
REQ-012 SHALL use on-the-fly conversion with registers Q and QM (P+1 bits each; invariant QM = Q - 1); no carry-propagate adder is allowed in the digit path.
REQ-013 SHALL update on each accepted digit d as follows: d = +1 gives Q <= {Q,1}, QM <= {Q,0}; d = 0 gives Q <= {Q,0}, QM <= {QM,1}; d = -1 gives Q <= {QM,1}, QM <= {QM,0}; each shift drops the MSB.
REQ-014 SHALL start each frame with Q = 0 and QM = all ones.
REQ-015 SHALL have a state machine with three states: ACCUM, PAD and HOLD.
REQ-016 SHALL behave as follows in ACCUM: readyArray_0 = 1; a digit is accepted when pValidArray_0 = 1; the digit counter cnt increments on each accepted digit.
REQ-017 SHALL move ACCUM to HOLD when it accepts a digit with last = 1 and cnt = P-1.
REQ-018 SHALL move ACCUM to PAD when it accepts a digit with last = 1 and cnt < P-1 (early last).
REQ-019 SHALL, on accepting digit P without last, move ACCUM to HOLD and set frame_err = 1; any following digits belong to the next frame.
REQ-020 SHALL behave as follows in PAD: readyArray_0 = 0; one zero digit is inserted per cycle until cnt = P; then move to HOLD; result = Q * 2^(P-n) for n received digits.
REQ-021 SHALL behave as follows in HOLD: readyArray_0 = 0; validArray_0 = 1; dataOutArray_0 = Q and frame_err are held stable while nReadyArray_0 = 0.
REQ-022 SHALL, on the HOLD handshake (nReadyArray_0 = 1), return to ACCUM, reinitialise Q, QM and cnt, and clear frame_err.
REQ-023 SHALL have a latency of exactly one cycle from accepting the final digit (or the last pad cycle) to validArray_0 = 1.
REQ-024 SHALL have a minimum period of P+1 cycles per word; the one bubble is in HOLD.
REQ-025 SHALL register validArray_0 and dataOutArray_0 directly from flops; there is no combinational path from input to output.
REQ-026 SHALL keep readyArray_0 independent of nReadyArray_0.
REQ-027 SHALL ignore pValidArray_0 outside ACCUM.
REQ-028 SHALL ignore dataInArray_0 when pValidArray_0 = 0.

Reset
REQ-029 SHALL, while rst = 1 at a clock edge, set the state to ACCUM, Q = 0, QM = all ones, cnt = 0, validArray_0 = 0, dataOutArray_0 = 0 and frame_err = 0.
REQ-030 SHALL drive readyArray_0 = 0 while rst = 1.
REQ-031 SHALL, on reset mid-frame or in HOLD, discard the partial or held word; no output handshake follows for it.

Structure
REQ-032 SHALL place in the shared package the digit-encoding constants (POS = 2'b10, NEG = 2'b01), the state encoding and the counter width function clog2(P+1).
REQ-033 SHALL contain one sub-module, msdf_otf_conv, holding Q/QM with inputs clk, rst, ce, init and digit[1:0] and output Q.
REQ-034 SHALL keep the FSM, counter and handshake logic in msdf_to_bin_op.

Verification (P = 4, output 5 bits)
REQ-035 SHALL cover a full frame: digits +1, 0, -1, +1 (last on the 4th digit) -> dataOutArray_0 = 5'b00111 (7), frame_err = 0, valid exactly one cycle after the 4th digit.
REQ-036 SHALL cover early last: digits +1, -1 (last on the 2nd digit) -> 2 PAD cycles with readyArray_0 = 0, then dataOutArray_0 = 5'b00100 (4).
REQ-037 SHALL cover all negative digits: -1, -1, -1, -1 with last -> 5'b10001 (-15); digits 11, 11, 11, 11 with last -> 5'b00000.
REQ-038 SHALL cover backpressure: nReadyArray_0 = 0 for 3 cycles in HOLD -> output word stable and readyArray_0 = 0; handshake on cycle 4; the next frame is accepted on the following cycle.
REQ-039 SHALL cover a missing last: 4 digits +1 without last -> 5'b01111 with frame_err = 1; a 5th digit offered before the handshake is not accepted until ACCUM.
REQ-040 SHALL cover reset mid-frame: rst = 1 after 2 digits -> validArray_0 = 0; the next 4-digit frame 0, 0, 0, +1 -> 5'b00001.

Source files
------------

// File: rtl/msdf_to_bin_op_pkg.sv
// msdf_to_bin_op_pkg
//   Shared definitions for the MSDF-to-binary converter:
//   - the signed-digit encodings (digit value = bit1 - bit0)
//   - the converter FSM state encoding
//   - clog2(), used to size the digit counter so it can hold P
package msdf_to_bin_op_pkg;

   localparam logic [1:0] DIG_POS = 2'b10;   // +1
   localparam logic [1:0] DIG_NEG = 2'b01;   // -1

   typedef enum logic [1:0] {
      ST_ACCUM = 2'd0,   // taking digits from upstream
      ST_PAD   = 2'd1,   // inserting zero digits after an early last
      ST_HOLD  = 2'd2    // presenting the word until downstream takes it
   } state_t;

   // Smallest r with 2**r >= v (returns at least 1 so a counter is never 0 bits).
   function automatic int clog2(input int unsigned v);
      int r;
      r = 1;
      for (int i = 1; i < 32; i++) begin
         if ((32'd1 << r) < v) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/msdf_otf_conv.sv
// msdf_otf_conv
//   On-the-fly conversion of a signed-digit stream (MSD first) into a
//   two's-complement word. Keeps Q and QM = Q - 1 so every digit, including
//   -1, is absorbed by a shift and select; no carry chain in the digit path.
// Ports
//   clk    : clock, rising edge
//   rst    : synchronous active-high reset (Q = 0, QM = all ones)
//   ce     : absorb 'digit' this cycle
//   init   : restart a frame (same effect as reset, wins over ce)
//   digit  : signed digit, 10 = +1, 01 = -1, 00/11 = 0
//   q      : current converted value Q (P+1 bits)
module msdf_otf_conv
   import msdf_to_bin_op_pkg::*;
#(
   parameter int unsigned P = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         ce,
   input  logic         init,
   input  logic [1:0]   digit,
   output logic [P:0]   q
);

   logic [P:0] q_r;
   logic [P:0] qm_r;
   logic [P:0] q_nx;
   logic [P:0] qm_nx;

   // Each shift drops the MSB; the register width already bounds the result.
   always_comb begin
      q_nx  = q_r;
      qm_nx = qm_r;
      case (digit)
         DIG_POS: begin
            q_nx  = {q_r[P-1:0], 1'b1};
            qm_nx = {q_r[P-1:0], 1'b0};
         end
         DIG_NEG: begin
            q_nx  = {qm_r[P-1:0], 1'b1};
            qm_nx = {qm_r[P-1:0], 1'b0};
         end
         default: begin
            q_nx  = {q_r[P-1:0], 1'b0};
            qm_nx = {qm_r[P-1:0], 1'b1};
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst || init) begin
         q_r  <= '0;
         qm_r <= '1;
      end else if (ce) begin
         q_r  <= q_nx;
         qm_r <= qm_nx;
      end
   end

   assign q = q_r;

endmodule

// File: rtl/msdf_to_bin_op.sv
// msdf_to_bin_op
//   Collects one MSDF frame (P digits, weight 2^-1 first) and hands it
//   downstream as a (P+1)-bit two's-complement integer Z = value * 2^P.
//   An early 'last' is completed with zero digits; a frame that reaches P
//   digits without 'last' is closed anyway and flagged with frame_err.
// Ports
//   clk, rst          : clock and synchronous active-high reset
//   dataInArray_0     : {last, digit[1:0]}
//   pValidArray_0     : upstream digit valid
//   readyArray_0      : digit accepted this cycle when valid (ACCUM only)
//   dataOutArray_0    : converted word (registered)
//   validArray_0      : converted word valid (registered)
//   nReadyArray_0     : downstream takes the word
//   frame_err         : word closed at digit P without last (with valid)
module msdf_to_bin_op
   import msdf_to_bin_op_pkg::*;
#(
   parameter int unsigned TARGET_PRECISION = 32'd16
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [2:0]                  dataInArray_0,
   input  logic                        pValidArray_0,
   output logic                        readyArray_0,
   output logic [TARGET_PRECISION:0]   dataOutArray_0,
   output logic                        validArray_0,
   input  logic                        nReadyArray_0,
   output logic                        frame_err
);

   localparam int unsigned P  = TARGET_PRECISION;
   localparam int          CW = clog2(P + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(P - 1);

   state_t        state, state_nx;
   logic [CW-1:0] cnt, cnt_nx;
   logic          valid_r, valid_nx;
   logic          err_r, err_nx;
   logic          ce, init;
   logic [1:0]    digit;

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ST_ACCUM;
         cnt     <= '0;
         valid_r <= 1'b0;
         err_r   <= 1'b0;
      end else begin
         state   <= state_nx;
         cnt     <= cnt_nx;
         valid_r <= valid_nx;
         err_r   <= err_nx;
      end
   end

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      valid_nx = valid_r;
      err_nx   = err_r;
      ce       = 1'b0;
      init     = 1'b0;
      digit    = 2'b00;
      case (state)
         ST_ACCUM: begin
            if (pValidArray_0) begin
               ce     = 1'b1;
               digit  = dataInArray_0[1:0];
               cnt_nx = cnt + 1'b1;
               if (cnt == CNT_LAST) begin
                  // Digit P closes the frame whether or not it carries last.
                  state_nx = ST_HOLD;
                  valid_nx = 1'b1;
                  err_nx   = ~dataInArray_0[2];
               end else if (dataInArray_0[2]) begin
                  state_nx = ST_PAD;
               end
            end
         end
         ST_PAD: begin
            // digit stays 00: shift in zeros until P digits are in.
            ce     = 1'b1;
            cnt_nx = cnt + 1'b1;
            if (cnt == CNT_LAST) begin
               state_nx = ST_HOLD;
               valid_nx = 1'b1;
            end
         end
         ST_HOLD: begin
            if (nReadyArray_0) begin
               state_nx = ST_ACCUM;
               init     = 1'b1;
               cnt_nx   = '0;
               valid_nx = 1'b0;
               err_nx   = 1'b0;
            end
         end
         default: state_nx = ST_ACCUM;
      endcase
   end

   msdf_otf_conv #(.P(P)) u_conv (
      .clk   (clk),
      .rst   (rst),
      .ce    (ce),
      .init  (init),
      .digit (digit),
      .q     (dataOutArray_0)
   );

   // Ready depends only on state, never on downstream.
   assign readyArray_0 = (state == ST_ACCUM) && !rst;
   assign validArray_0 = valid_r;
   assign frame_err    = err_r;

endmodule

// File: tb/tb_msdf_to_bin_op.sv
module tb_msdf_to_bin_op;
   localparam int P = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic [2:0]   din;
   logic         pv;
   logic         ready;
   logic [P:0]   dout;
   logic         valid;
   logic         nready;
   logic         ferr;

   typedef struct {
      logic [P:0] data;
      logic       err;
      int         cyc;
   } exp_t;

   exp_t sb[$];
   int   cyc = 0;
   int   n_chk = 0;
   int   n_fail = 0;
   logic in_hold = 1'b0;

   msdf_to_bin_op #(.TARGET_PRECISION(P)) dut (
      .clk            (clk),
      .rst            (rst),
      .dataInArray_0  (din),
      .pValidArray_0  (pv),
      .readyArray_0   (ready),
      .dataOutArray_0 (dout),
      .validArray_0   (valid),
      .nReadyArray_0  (nready),
      .frame_err      (ferr)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int got, input int exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   // Offer one digit, wait (bounded) for ready, return the accepting cycle.
   task automatic send(input logic [1:0] d, input logic lst, output int acc);
      int t;
      t = 0;
      pv  = 1'b1;
      din = {lst, d};
      while (!ready && t < 40) begin
         @(posedge clk); #1;
         t++;
      end
      if (t >= 40) chk("ready_timeout", 0, 1);
      @(posedge clk); #1;
      acc = cyc;
      pv  = 1'b0;
      din = 3'b000;
   endtask

   task automatic push(input logic [P:0] data, input logic err, input int c);
      exp_t e;
      e.data = data; e.err = err; e.cyc = c;
      sb.push_back(e);
   endtask

   // Monitor: every cycle the word is valid it must match the head of the
   // scoreboard (covers stability under backpressure); pop on handshake.
   always @(negedge clk) begin
      if (rst) begin
         in_hold <= 1'b0;
      end else if (valid) begin
         if (sb.size() == 0) begin
            chk("unexpected_valid", 1, 0);
         end else begin
            if (!in_hold) chk("latency_cycle", cyc, sb[0].cyc);
            chk("word", int'(dout), int'(sb[0].data));
            chk("frame_err", int'(ferr), int'(sb[0].err));
            if (nready) begin
               void'(sb.pop_front());
               in_hold <= 1'b0;
            end else begin
               in_hold <= 1'b1;
            end
         end
      end
   end

   initial begin
      int a, e;
      rst = 1'b1; pv = 1'b0; din = 3'b000; nready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ready", int'(ready), 0);
      chk("rst_valid", int'(valid), 0);
      chk("rst_data", int'(dout), 0);
      chk("rst_ferr", int'(ferr), 0);
      rst = 1'b0;
      #1;
      chk("ready_after_rst", int'(ready), 1);

      // Full frame +1 0 -1 +1 -> 7
      send(2'b10, 0, a); send(2'b00, 0, a); send(2'b01, 0, a); send(2'b10, 1, a);
      push(5'b00111, 1'b0, a);
      @(posedge clk); #1;

      // Early last +1 -1 -> two pad cycles -> 4
      send(2'b10, 0, a); send(2'b01, 1, a);
      push(5'b00100, 1'b0, a + 2);
      chk("pad_ready_0", int'(ready), 0);
      @(posedge clk); #1;
      chk("pad_ready_1", int'(ready), 0);
      @(posedge clk); #1;
      chk("hold_ready", int'(ready), 0);
      @(posedge clk); #1;

      // All -1 -> -15
      for (int i = 0; i < P; i++) send(2'b01, (i == P - 1), a);
      push(5'b10001, 1'b0, a);
      @(posedge clk); #1;

      // 11 encodes zero -> 0
      for (int i = 0; i < P; i++) send(2'b11, (i == P - 1), a);
      push(5'b00000, 1'b0, a);
      @(posedge clk); #1;

      // Backpressure: 3 stalled cycles, handshake on the 4th, then -1 +1 0 +1 -> -3
      nready = 1'b0;
      send(2'b10, 0, a); send(2'b00, 0, a); send(2'b01, 0, a); send(2'b10, 1, a);
      push(5'b00111, 1'b0, a);
      e = a;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         chk("bp_ready", int'(ready), 0);
         chk("bp_valid", int'(valid), 1);
      end
      nready = 1'b1;
      send(2'b01, 0, a);
      chk("bp_next_accept", a, e + 5);
      send(2'b10, 0, a); send(2'b00, 0, a); send(2'b10, 1, a);
      push(5'b11101, 1'b0, a);
      @(posedge clk); #1;

      // Missing last: 4x +1 -> 15 with frame_err; 5th digit waits for ACCUM
      nready = 1'b0;
      for (int i = 0; i < P; i++) send(2'b10, 0, a);
      push(5'b01111, 1'b1, a);
      e = a;
      pv = 1'b1; din = 3'b010;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         chk("ml_5th_blocked", int'(ready), 0);
      end
      nready = 1'b1;
      send(2'b10, 0, a);
      chk("ml_5th_accept", a, e + 5);
      send(2'b00, 0, a); send(2'b00, 0, a); send(2'b10, 1, a);
      push(5'b01001, 1'b0, a);
      @(posedge clk); #1;

      // Reset mid-frame discards the partial word
      send(2'b10, 0, a); send(2'b10, 0, a);
      rst = 1'b1;
      @(posedge clk); #1;
      chk("midrst_ready", int'(ready), 0);
      chk("midrst_valid", int'(valid), 0);
      rst = 1'b0;
      @(posedge clk); #1;
      chk("postrst_valid", int'(valid), 0);
      chk("postrst_ready", int'(ready), 1);
      send(2'b00, 0, a); send(2'b00, 0, a); send(2'b00, 0, a); send(2'b10, 1, a);
      push(5'b00001, 1'b0, a);

      // Drain scoreboard (bounded)
      for (int i = 0; i < 50 && sb.size() != 0; i++) @(posedge clk);
      @(negedge clk);
      chk("scoreboard_empty", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
